// File: rtl/proc_states_control_if.sv
// Handshake and status bundle between the proc_states control FSM and its datapath.
// PROC_STATES_CTRL_SINGLE_STEP_EN adds the step_mode/step inputs.
interface proc_states_control_if #(
    parameter int RETIRE_W  = 16,
    parameter int ILLEGAL_W = 8
);
    logic [15:0]          instr_in;
    logic                 cond_zero;
    logic                 imem_ready;
    logic                 dmem_ready;
    logic [4:0]           operation;
    logic [2:0]           state;
    logic                 halted;
    logic                 retire_pulse;
    logic [RETIRE_W-1:0]  retire_count;
    logic [ILLEGAL_W-1:0] illegal_count;
`ifdef PROC_STATES_CTRL_SINGLE_STEP_EN
    logic                 step_mode;
    logic                 step;

    modport master (
        input  instr_in, cond_zero, imem_ready, dmem_ready, step_mode, step,
        output operation, state, halted, retire_pulse, retire_count, illegal_count
    );
    modport slave (
        output instr_in, cond_zero, imem_ready, dmem_ready, step_mode, step,
        input  operation, state, halted, retire_pulse, retire_count, illegal_count
    );
`else
    modport master (
        input  instr_in, cond_zero, imem_ready, dmem_ready,
        output operation, state, halted, retire_pulse, retire_count, illegal_count
    );
    modport slave (
        output instr_in, cond_zero, imem_ready, dmem_ready,
        input  operation, state, halted, retire_pulse, retire_count, illegal_count
    );
`endif
endinterface

// File: rtl/proc_states_control.sv
// Multicycle Fetch/Decode/Execute/Memory/Writeback control FSM for proc_states.
// Optional single-step support is compiled in with PROC_STATES_CTRL_SINGLE_STEP_EN.
module proc_states_control #(
    parameter int RETIRE_W  = 16,
    parameter int ILLEGAL_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    proc_states_control_if.master bus
);

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEMORY    = 3'd3,
        WRITEBACK = 3'd4,
`ifdef PROC_STATES_CTRL_SINGLE_STEP_EN
        HALT      = 3'd5,
        STEP_WAIT = 3'd6
`else
        HALT      = 3'd5
`endif
    } state_e;

    // Numeric values match the datapath's proc_states_operations_t suffixes.
    typedef enum logic [4:0] {
        OP_IDLE        = 5'd0,
        OP_FETCH       = 5'd1,
        OP_BR_TAKEN    = 5'd2,
        OP_DECODE_ONLY = 5'd3,
        OP_JMP         = 5'd4,
        OP_DECODE      = 5'd5,
        OP_EX_STORE    = 5'd6,
        OP_EX_ADD      = 5'd7,
        OP_EX_OR       = 5'd8,
        OP_EX_ADDI     = 5'd10,
        OP_EX_ORI      = 5'd11,
        OP_EX_LOAD     = 5'd12,
        OP_MEM_LOAD    = 5'd14,
        OP_MEM_ACCESS  = 5'd15,
        OP_WB_LOAD     = 5'd16,
        OP_WB_RR       = 5'd17,
        OP_WB_RI       = 5'd18,
        OP_WB_STORE    = 5'd19
    } op_e;

    localparam logic [3:0] OPC_NOP   = 4'h0;
    localparam logic [3:0] OPC_ADD   = 4'h1;
    localparam logic [3:0] OPC_OR    = 4'h2;
    localparam logic [3:0] OPC_ADDI  = 4'h3;
    localparam logic [3:0] OPC_ORI   = 4'h4;
    localparam logic [3:0] OPC_LOAD  = 4'h5;
    localparam logic [3:0] OPC_STORE = 4'h6;
    localparam logic [3:0] OPC_BR    = 4'h7;
    localparam logic [3:0] OPC_JMP   = 4'h8;
    localparam logic [3:0] OPC_HALT  = 4'hF;

    state_e               state_q, state_d;
    logic                 halted_q, halted_d;
    logic [RETIRE_W-1:0]  retire_count_q, retire_count_d;
    logic [ILLEGAL_W-1:0] illegal_count_q, illegal_count_d;

    op_e        op;
    logic       retire;
    logic       illegal;
    state_e     retire_dest;
    logic [3:0] opc;

    assign opc = bus.instr_in[15:12];

`ifdef PROC_STATES_CTRL_SINGLE_STEP_EN
    assign retire_dest = bus.step_mode ? STEP_WAIT : FETCH;
`else
    assign retire_dest = FETCH;
`endif

    always_comb begin
        state_d = state_q;
        op      = OP_IDLE;
        retire  = 1'b0;
        illegal = 1'b0;

        unique case (state_q)
            FETCH: begin
                if (bus.imem_ready) begin
                    op      = OP_FETCH;
                    state_d = DECODE;
                end
            end

            DECODE: begin
                case (opc)
                    OPC_ADD, OPC_OR, OPC_ADDI, OPC_ORI, OPC_LOAD, OPC_STORE: begin
                        op      = OP_DECODE;
                        state_d = EXECUTE;
                    end
                    OPC_BR: begin
                        op      = bus.cond_zero ? OP_BR_TAKEN : OP_DECODE_ONLY;
                        retire  = 1'b1;
                        state_d = retire_dest;
                    end
                    OPC_JMP: begin
                        op      = OP_JMP;
                        retire  = 1'b1;
                        state_d = retire_dest;
                    end
                    OPC_NOP: begin
                        op      = OP_DECODE_ONLY;
                        retire  = 1'b1;
                        state_d = retire_dest;
                    end
                    OPC_HALT: begin
                        op      = OP_IDLE;
                        retire  = 1'b1;
                        state_d = HALT;
                    end
                    default: begin
                        op      = OP_DECODE_ONLY;
                        illegal = 1'b1;
                        retire  = 1'b1;
                        state_d = retire_dest;
                    end
                endcase
            end

            // instr_in is held by the datapath until the next fetch, so re-decoding is safe.
            EXECUTE: begin
                state_d = MEMORY;
                case (opc)
                    OPC_ADD:   op = OP_EX_ADD;
                    OPC_OR:    op = OP_EX_OR;
                    OPC_ADDI:  op = OP_EX_ADDI;
                    OPC_ORI:   op = OP_EX_ORI;
                    OPC_LOAD:  op = OP_EX_LOAD;
                    OPC_STORE: op = OP_EX_STORE;
                    default:   op = OP_IDLE;
                endcase
            end

            MEMORY: begin
                case (opc)
                    OPC_LOAD: begin
                        if (bus.dmem_ready) begin
                            op      = OP_MEM_LOAD;
                            state_d = WRITEBACK;
                        end
                    end
                    OPC_STORE: begin
                        if (bus.dmem_ready) begin
                            op      = OP_MEM_ACCESS;
                            state_d = WRITEBACK;
                        end
                    end
                    OPC_ADD, OPC_OR, OPC_ADDI, OPC_ORI: begin
                        op      = OP_MEM_ACCESS;
                        state_d = WRITEBACK;
                    end
                    default: state_d = FETCH;
                endcase
            end

            WRITEBACK: begin
                retire  = 1'b1;
                state_d = retire_dest;
                case (opc)
                    OPC_LOAD:          op = OP_WB_LOAD;
                    OPC_ADD, OPC_OR:   op = OP_WB_RR;
                    OPC_ADDI, OPC_ORI: op = OP_WB_RI;
                    OPC_STORE:         op = OP_WB_STORE;
                    default:           op = OP_IDLE;
                endcase
            end

            HALT: state_d = HALT;

`ifdef PROC_STATES_CTRL_SINGLE_STEP_EN
            STEP_WAIT: begin
                if (bus.step) begin
                    state_d = FETCH;
                end
            end
`endif

            default: state_d = FETCH;
        endcase

        // Reset abandons any in-flight instruction and blocks datapath updates.
        if (rst) begin
            state_d = FETCH;
            op      = OP_IDLE;
            retire  = 1'b0;
            illegal = 1'b0;
        end
    end

    always_comb begin
        halted_d        = (state_d == HALT);
        retire_count_d  = retire_count_q + RETIRE_W'(retire);
        illegal_count_d = illegal_count_q;
        if (illegal && (illegal_count_q != {ILLEGAL_W{1'b1}})) begin
            illegal_count_d = illegal_count_q + ILLEGAL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= FETCH;
            halted_q        <= 1'b0;
            retire_count_q  <= '0;
            illegal_count_q <= '0;
        end else begin
            state_q         <= state_d;
            halted_q        <= halted_d;
            retire_count_q  <= retire_count_d;
            illegal_count_q <= illegal_count_d;
        end
    end

    assign bus.operation     = op;
    assign bus.retire_pulse  = retire;
    assign bus.state         = state_q;
    assign bus.halted        = halted_q;
    assign bus.retire_count  = retire_count_q;
    assign bus.illegal_count = illegal_count_q;

endmodule
